// File: rtl/vram_blitter_pkg.sv
// Shared types and width helpers for the VRAM blitter write path.
// Holds the FSM state type and the full-precision address width used before clipping.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } blit_state_t;

    // Wide enough that y*STRIDE + x never wraps before the clip test.
    function automatic int full_aw(input int hw, input int vw);
        return hw + vw + 1;
    endfunction

endpackage

// File: rtl/vram_blitter_if.sv
// Pixel stream in, VRAM write port out; the blitter is the slave side.
interface vram_blitter_if #(
    parameter int DATA_WIDTH = 13,
    parameter int AWIDTH     = 15
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  wr_en;
    logic [AWIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport slave (
        input  s_data, s_valid,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output s_data, s_valid,
        input  s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/vram_blitter_addr.sv
// Combinational destination transform: mirror, offset, y*STRIDE+x, and clip.
// Inverse of the read-side transformer; in_range low means the beat is dropped.
module blit_addr
    import blit_pkg::*;
#(
    parameter int AWIDTH = 15,
    parameter int HWIDTH = 12,
    parameter int VWIDTH = 12,
    parameter int STRIDE = 160,
    parameter int DEPTH  = 19200
) (
    input  logic [HWIDTH-1:0] dst_x,
    input  logic [VWIDTH-1:0] dst_y,
    input  logic [HWIDTH-1:0] width,
    input  logic [VWIDTH-1:0] height,
    input  logic [HWIDTH-1:0] col,
    input  logic [VWIDTH-1:0] row,
    input  logic              hflip,
    input  logic              vflip,
    output logic [AWIDTH-1:0] addr,
    output logic              in_range
);
    localparam int FW = full_aw(HWIDTH, VWIDTH);
    localparam logic [HWIDTH:0] STRIDE_X = (HWIDTH+1)'(STRIDE);
    localparam logic [FW-1:0]   STRIDE_F = FW'(STRIDE);
    localparam logic [FW-1:0]   DEPTH_F  = FW'(DEPTH);

    logic [HWIDTH-1:0] xo;
    logic [VWIDTH-1:0] yo;
    logic [HWIDTH:0]   x;
    logic [VWIDTH:0]   y;
    logic [FW-1:0]     full;

    always_comb begin
        xo       = hflip ? (width - col - HWIDTH'(1)) : col;
        yo       = vflip ? (height - row - VWIDTH'(1)) : row;
        x        = {1'b0, dst_x} + {1'b0, xo};
        y        = {1'b0, dst_y} + {1'b0, yo};
        full     = FW'(y) * STRIDE_F + FW'(x);
        addr     = full[AWIDTH-1:0];
        // Columns past the row end would alias into the next row, so drop them too.
        in_range = (x < STRIDE_X) && (full < DEPTH_F);
    end
endmodule

// File: rtl/vram_blitter.sv
// Rectangle blitter: streams raster-order pixels into VRAM at a programmed
// destination with optional mirroring and clipping; one pixel per cycle.
module vram_blitter
    import blit_pkg::*;
#(
    parameter int DATA_WIDTH = 13,
    parameter int AWIDTH     = 15,
    parameter int HWIDTH     = 12,
    parameter int VWIDTH     = 12,
    parameter int STRIDE     = 160,
    parameter int DEPTH      = 19200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [HWIDTH-1:0] dst_x,
    input  logic [VWIDTH-1:0] dst_y,
    input  logic [HWIDTH-1:0] width,
    input  logic [VWIDTH-1:0] height,
    input  logic              hflip,
    input  logic              vflip,
    vram_blitter_if.slave     bus,
    output logic              busy,
    output logic              done
);
    blit_state_t state, nstate;

    logic [HWIDTH-1:0]     dx_q, w_q, col;
    logic [VWIDTH-1:0]     dy_q, h_q, row;
    logic                  hf_q, vf_q;
    logic                  wr_en_q;
    logic [AWIDTH-1:0]     wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic              accept, last_col, last_row;
    logic [AWIDTH-1:0] addr;
    logic              in_range;

    blit_addr #(
        .AWIDTH (AWIDTH),
        .HWIDTH (HWIDTH),
        .VWIDTH (VWIDTH),
        .STRIDE (STRIDE),
        .DEPTH  (DEPTH)
    ) u_addr (
        .dst_x    (dx_q),
        .dst_y    (dy_q),
        .width    (w_q),
        .height   (h_q),
        .col      (col),
        .row      (row),
        .hflip    (hf_q),
        .vflip    (vf_q),
        .addr     (addr),
        .in_range (in_range)
    );

    assign accept   = (state == RUN) && bus.s_valid;
    assign last_col = (col == w_q - HWIDTH'(1));
    assign last_row = (row == h_q - VWIDTH'(1));

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (start) nstate = ((width == '0) || (height == '0)) ? DONE : RUN;
            RUN:  if (accept && last_col && last_row) nstate = DONE;
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    assign bus.s_ready = (state == RUN);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dx_q      <= '0;
            dy_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            hf_q      <= 1'b0;
            vf_q      <= 1'b0;
            col       <= '0;
            row       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state   <= nstate;
            wr_en_q <= accept && in_range;
            if (accept && in_range) begin
                wr_addr_q <= addr;
                wr_data_q <= bus.s_data;
            end
            // Parameters are captured only from IDLE, so a start mid-blit is inert.
            if (state == IDLE && start) begin
                dx_q <= dst_x;
                dy_q <= dst_y;
                w_q  <= width;
                h_q  <= height;
                hf_q <= hflip;
                vf_q <= vflip;
                col  <= '0;
                row  <= '0;
            end else if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + VWIDTH'(1);
                end else begin
                    col <= col + HWIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vram_blitter.sv
// Scoreboard bench for vram_blitter: drivers push expected writes, a negedge
// monitor pops and compares every wr_en beat.
module tb_vram_blitter;
    localparam int DW = 13;
    localparam int AW = 15;
    localparam int HW = 12;
    localparam int VW = 12;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [HW-1:0] dst_x = '0, width = '0;
    logic [VW-1:0] dst_y = '0, height = '0;
    logic          hflip = 1'b0, vflip = 1'b0;
    logic          busy, done;

    int vecs = 0;
    int errs = 0;
    wr_t exp_q[$];

    vram_blitter_if #(.DATA_WIDTH(DW), .AWIDTH(AW)) bif ();

    vram_blitter #(
        .DATA_WIDTH(DW), .AWIDTH(AW), .HWIDTH(HW), .VWIDTH(VW),
        .STRIDE(160), .DEPTH(19200)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .dst_x  (dst_x),
        .dst_y  (dst_y),
        .width  (width),
        .height (height),
        .hflip  (hflip),
        .vflip  (vflip),
        .bus    (bif.slave),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bif.wr_en) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write addr=%0d data=%0d (no write expected)",
                         bif.wr_addr, bif.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bif.wr_addr !== e.addr || bif.wr_data !== e.data) begin
                    errs++;
                    $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                             bif.wr_addr, bif.wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic expect_wr(input int addr, input int data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = DW'(data);
        exp_q.push_back(e);
    endtask

    // Runs one blit of n beats (data 1..n). gap inserts an idle cycle before each beat;
    // poke fires a conflicting start on beat 1; abort stops after n beats without DONE checks.
    task automatic run_blit(input int x, input int y, input int w, input int h,
                            input bit hf, input bit vf, input int n,
                            input bit gap, input bit poke, input bit abort);
        @(posedge clk); #1;
        start = 1'b1; dst_x = HW'(x); dst_y = VW'(y); width = HW'(w); height = VW'(h);
        hflip = hf; vflip = vf;
        @(posedge clk); #1;
        start = 1'b0; dst_x = '0; dst_y = '0; width = '0; height = '0; hflip = 0; vflip = 0;
        check("busy_after_start", busy, 1);
        if (n == 0) begin
            check("zero_done", done, 1);
            check("zero_ready", bif.s_ready, 0);
        end else begin
            check("ready_after_start", bif.s_ready, 1);
        end
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                bif.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            bif.s_data  = DW'(i + 1);
            bif.s_valid = 1'b1;
            if (poke && i == 1) begin
                start = 1'b1; dst_x = 12'd50; dst_y = 12'd50; width = 12'd5; height = 12'd5;
            end
            begin
                int t = 0;
                while (!bif.s_ready && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (t >= 100) begin
                    errs++;
                    $display("FAIL ready_timeout beat=%0d waited=%0d cycles", i, t);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        bif.s_valid = 1'b0;
        if (!abort) begin
            if (n != 0) check("done_on_last_write", done, 1);
            check("busy_in_done", busy, 1);
            check("ready_in_done", bif.s_ready, 0);
            @(posedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_ready", bif.s_ready, 0);
        end
    endtask

    initial begin
        bif.s_valid = 1'b0;
        bif.s_data  = '0;
        #12;
        check("rst_ready", bif.s_ready, 0);
        check("rst_wr_en", bif.wr_en, 0);
        check("rst_wr_addr", bif.wr_addr, 0);
        check("rst_wr_data", bif.wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // 4x2 at (10,5), no flip.
        for (int i = 0; i < 4; i++) expect_wr(810 + i, 1 + i);
        for (int i = 0; i < 4; i++) expect_wr(970 + i, 5 + i);
        run_blit(10, 5, 4, 2, 0, 0, 8, 0, 0, 0);

        // Same rectangle mirrored both ways.
        for (int i = 0; i < 4; i++) expect_wr(973 - i, 1 + i);
        for (int i = 0; i < 4; i++) expect_wr(813 - i, 5 + i);
        run_blit(10, 5, 4, 2, 1, 1, 8, 0, 0, 0);

        // Right-edge clip: columns 160,161 dropped on each row.
        expect_wr(158, 1); expect_wr(159, 2);
        expect_wr(318, 5); expect_wr(319, 6);
        run_blit(158, 0, 4, 2, 0, 0, 8, 0, 0, 0);

        // Bottom clip: last row is 119, row 120 falls past DEPTH.
        expect_wr(19040, 1); expect_wr(19041, 2);
        run_blit(0, 119, 2, 2, 0, 0, 4, 0, 0, 0);

        // Gapped source, with a conflicting start mid-blit that must be ignored.
        expect_wr(482, 1); expect_wr(483, 2); expect_wr(484, 3);
        run_blit(2, 3, 3, 1, 0, 0, 3, 1, 1, 0);

        // Zero-width blit: DONE straight away, no writes.
        run_blit(7, 7, 0, 3, 0, 0, 0, 0, 0, 0);

        // Reset after 3 of 8 beats.
        expect_wr(810, 1); expect_wr(811, 2); expect_wr(812, 3);
        run_blit(10, 5, 4, 2, 0, 0, 3, 0, 0, 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", bif.wr_en, 0);
        check("arst_wr_addr", bif.wr_addr, 0);
        check("arst_wr_data", bif.wr_data, 0);
        check("arst_ready", bif.s_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        expect_wr(161, 1); expect_wr(162, 2);
        run_blit(1, 1, 2, 1, 0, 0, 2, 0, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
